// File: rtl/wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// wb_arbiter_rr
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port.
// A grant is held for as long as its master keeps cyc asserted, so bursts
// are never split. When the master releases cyc, a waiting master can take
// the bus in the next cycle with no idle cycle in between. An optional
// watchdog ends a cycle the slave stalls on by returning ERR to its master.
//
// Ports
//   wb_clk_i, wb_rst_ni      clock, synchronous active-low reset
//   wbm_*_i                  packed master buses, master m at [m*W +: W]
//   wbm_dat_o                slave read data, broadcast to all masters
//   wbm_ack/err/rty_o        per-master responses, gated by the grant
//   wbs_*_o / wbs_*_i        slave port, muxed from the granted master
//   grant_o                  one-hot current grant (0 = idle)
//   timeout_o                one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_arbiter_rr #(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 256
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic [NUM_MASTERS*aw-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*dw-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
    output logic [dw-1:0]             wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [aw-1:0]             wbs_adr_o,
    output logic [dw-1:0]             wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [dw-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic                      timeout_o
);

    localparam int MW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [MW-1:0]          last;
    logic [MW-1:0]          last_nxt;
    logic [MW-1:0]          cand;
    logic                   gnt_cyc;
    logic                   wd_fire;

    // Per-master views of the packed buses so the slave mux can index by last.
    logic [aw-1:0] m_adr [NUM_MASTERS];
    logic [dw-1:0] m_dat [NUM_MASTERS];
    logic [3:0]    m_sel [NUM_MASTERS];
    logic [2:0]    m_cti [NUM_MASTERS];
    logic [1:0]    m_bte [NUM_MASTERS];

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_unpack
        assign m_adr[m] = wbm_adr_i[m*aw +: aw];
        assign m_dat[m] = wbm_dat_i[m*dw +: dw];
        assign m_sel[m] = wbm_sel_i[m*4 +: 4];
        assign m_cti[m] = wbm_cti_i[m*3 +: 3];
        assign m_bte[m] = wbm_bte_i[m*2 +: 2];
    end

    // The granted master still wants the bus; also 0 when idle.
    assign gnt_cyc = |(grant & wbm_cyc_i);

    // Round-robin scan starting after the last winner. The last winner is
    // the final candidate, so a sole requester is granted again.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        grant_nxt = grant;
        last_nxt  = last;
        cand      = '0;
        if (!gnt_cyc) begin
            grant_nxt = '0;
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                cand = MW'((int'(last) + k) % NUM_MASTERS);
                if (grant_nxt == '0 && wbm_cyc_i[cand]) begin
                    grant_nxt = NUM_MASTERS'(1) << cand;
                    last_nxt  = cand;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: state uses non-blocking assignments so every register sees
        // the pre-edge value of every other register.
        if (!wb_rst_ni) begin
            grant <= '0;
            last  <= MW'(NUM_MASTERS - 1);
        end else begin
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // While a grant is held, last is the index of the granted master.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (|grant) begin
            wbs_adr_o = m_adr[last];
            wbs_dat_o = m_dat[last];
            wbs_sel_o = m_sel[last];
            wbs_we_o  = wbm_we_i[last];
            wbs_cyc_o = wbm_cyc_i[last];
            wbs_stb_o = wbm_stb_i[last];
            wbs_cti_o = m_cti[last];
            wbs_bte_o = m_bte[last];
        end
    end

    if (TIMEOUT > 0) begin : g_wd
        localparam int WDW = $clog2(TIMEOUT + 1);

        logic [WDW-1:0] wd_cnt;
        logic           stalled;

        assign stalled = wbs_cyc_o & wbs_stb_o & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);
        // A slave response in the firing cycle clears stalled, so ack wins.
        assign wd_fire = stalled & (wd_cnt == WDW'(TIMEOUT - 1));

        always_ff @(posedge wb_clk_i) begin
            if (!wb_rst_ni) begin
                wd_cnt <= '0;
            end else if (!stalled || wd_fire || (grant_nxt != grant)) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end else begin : g_no_wd
        assign wd_fire = 1'b0;
    end

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = {NUM_MASTERS{wbs_ack_i}} & grant;
    assign wbm_rty_o = {NUM_MASTERS{wbs_rty_i}} & grant;
    assign wbm_err_o = {NUM_MASTERS{wbs_err_i | wd_fire}} & grant;
    assign grant_o   = grant;
    assign timeout_o = wd_fire;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_rr
// Directed bench for wb_arbiter_rr with 4 masters and an 8-cycle watchdog.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected values are written out per step.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_rr;

    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_ni;
    logic [NM*AW-1:0] wbm_adr_i;
    logic [NM*DW-1:0] wbm_dat_i;
    logic [NM*4-1:0]  wbm_sel_i;
    logic [NM-1:0]    wbm_we_i;
    logic [NM-1:0]    wbm_cyc_i;
    logic [NM-1:0]    wbm_stb_i;
    logic [NM*3-1:0]  wbm_cti_i;
    logic [NM*2-1:0]  wbm_bte_i;
    logic [DW-1:0]    wbm_dat_o;
    logic [NM-1:0]    wbm_ack_o;
    logic [NM-1:0]    wbm_err_o;
    logic [NM-1:0]    wbm_rty_o;
    logic [AW-1:0]    wbs_adr_o;
    logic [DW-1:0]    wbs_dat_o;
    logic [3:0]       wbs_sel_o;
    logic             wbs_we_o;
    logic             wbs_cyc_o;
    logic             wbs_stb_o;
    logic [2:0]       wbs_cti_o;
    logic [1:0]       wbs_bte_o;
    logic [DW-1:0]    wbs_dat_i;
    logic             wbs_ack_i;
    logic             wbs_err_i;
    logic             wbs_rty_i;
    logic [NM-1:0]    grant_o;
    logic             timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter_rr #(
        .dw(DW), .aw(AW), .NUM_MASTERS(NM), .TIMEOUT(TO)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .wbm_adr_i(wbm_adr_i),
        .wbm_dat_i(wbm_dat_i),
        .wbm_sel_i(wbm_sel_i),
        .wbm_we_i (wbm_we_i),
        .wbm_cyc_i(wbm_cyc_i),
        .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i),
        .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o),
        .wbs_dat_o(wbs_dat_o),
        .wbs_sel_o(wbs_sel_o),
        .wbs_we_o (wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o),
        .wbs_stb_o(wbs_stb_o),
        .wbs_cti_o(wbs_cti_o),
        .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i),
        .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i),
        .grant_o  (grant_o),
        .timeout_o(timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge (input drive point).
    task automatic next_cycle();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Wait for the falling edge (output sample point).
    task automatic settle();
        @(negedge wb_clk_i);
    endtask

    task automatic set_m(input int m, input logic cyc, input logic [2:0] cti);
        wbm_cyc_i[m]       = cyc;
        wbm_stb_i[m]       = cyc;
        wbm_cti_i[m*3 +: 3] = cti;
    endtask

    task automatic clear_bus();
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
        wbm_cti_i = '0;
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
    endtask

    // Two reset edges; returns in the first cycle with reset released.
    task automatic do_reset();
        clear_bus();
        wb_rst_ni = 1'b0;
        next_cycle();
        next_cycle();
        wb_rst_ni = 1'b1;
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        for (int m = 0; m < NM; m++) begin
            wbm_adr_i[m*AW +: AW] = 32'h1000 * (m + 1);
            wbm_dat_i[m*DW +: DW] = 32'hA000_0000 + m;
            wbm_sel_i[m*4 +: 4]   = 4'(m + 1);
        end
        wbm_we_i  = 4'b0101;
        wbm_bte_i = 8'b11_10_01_00;
        wbs_dat_i = '0;
        clear_bus();

        // ---- Reset: a request and an ack present must not leak through.
        set_m(2, 1'b1, 3'b000);
        wbs_ack_i = 1'b1;
        next_cycle();
        next_cycle();
        settle();
        check("rst_grant",   grant_o,   4'b0000);
        check("rst_cyc",     wbs_cyc_o, 1'b0);
        check("rst_adr",     wbs_adr_o, 32'h0);
        check("rst_ack",     wbm_ack_o, 4'b0000);
        check("rst_timeout", timeout_o, 1'b0);

        // ---- Single master m2, slave acks one cycle after stb.
        next_cycle();
        wbs_ack_i = 1'b0;
        wb_rst_ni = 1'b1;
        settle();
        check("m2_req_cyc", wbs_cyc_o, 1'b0);
        next_cycle();
        settle();
        check("m2_grant", grant_o,   4'b0100);
        check("m2_cyc",   wbs_cyc_o, 1'b1);
        check("m2_adr",   wbs_adr_o, 32'h3000);
        check("m2_we",    wbs_we_o,  1'b1);
        check("m2_sel",   wbs_sel_o, 4'd3);
        check("m2_noack", wbm_ack_o, 4'b0000);
        next_cycle();
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'hDEAD_BEEF;
        settle();
        check("m2_ack",   wbm_ack_o, 4'b0100);
        check("m2_err",   wbm_err_o, 4'b0000);
        check("m2_rdata", wbm_dat_o, 32'hDEAD_BEEF);
        next_cycle();
        wbs_ack_i = 1'b0;
        set_m(2, 1'b0, 3'b000);
        settle();
        check("m2_drop_cyc", wbs_cyc_o, 1'b0);
        next_cycle();
        settle();
        check("m2_idle", grant_o, 4'b0000);

        // ---- All masters request; rotation 0,1,2,3,0 with no idle grant.
        do_reset();
        for (int m = 0; m < NM; m++) set_m(m, 1'b1, 3'b000);
        next_cycle();
        for (int m = 0; m < NM; m++) begin
            if (m == 1) set_m(0, 1'b1, 3'b000);
            wbs_ack_i = 1'b1;
            settle();
            check($sformatf("rr_grant%0d", m), grant_o,   4'b0001 << m);
            check($sformatf("rr_ack%0d", m),   wbm_ack_o, 4'b0001 << m);
            check($sformatf("rr_adr%0d", m),   wbs_adr_o, 32'h1000 * (m + 1));
            next_cycle();
            wbs_ack_i = 1'b0;
            set_m(m, 1'b0, 3'b000);
            settle();
            check($sformatf("rr_hold%0d", m), grant_o,   4'b0001 << m);
            check($sformatf("rr_drop%0d", m), wbs_cyc_o, 1'b0);
            next_cycle();
        end
        settle();
        check("rr_wrap", grant_o, 4'b0001);
        check("rr_wrap_cyc", wbs_cyc_o, 1'b1);

        // ---- m1 incrementing burst of 4 while m3 waits.
        do_reset();
        set_m(1, 1'b1, 3'b010);
        set_m(3, 1'b1, 3'b000);
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            if (b == 3) set_m(1, 1'b1, 3'b111);
            wbs_ack_i = 1'b1;
            settle();
            check($sformatf("burst_grant%0d", b), grant_o,   4'b0010);
            check($sformatf("burst_ack%0d", b),   wbm_ack_o, 4'b0010);
            check($sformatf("burst_cti%0d", b),   wbs_cti_o, (b == 3) ? 3'b111 : 3'b010);
            next_cycle();
        end
        wbs_ack_i = 1'b0;
        set_m(1, 1'b0, 3'b000);
        settle();
        check("burst_release_grant", grant_o, 4'b0010);
        next_cycle();
        settle();
        check("burst_m3_grant", grant_o,   4'b1000);
        check("burst_m3_cyc",   wbs_cyc_o, 1'b1);
        check("burst_m3_bte",   wbs_bte_o, 2'b11);

        // ---- RTY to m3, then reset in the middle of an m1 burst.
        next_cycle();
        wbs_rty_i = 1'b1;
        settle();
        check("rty_m3",     wbm_rty_o, 4'b1000);
        check("rty_no_ack", wbm_ack_o, 4'b0000);
        check("rty_no_err", wbm_err_o, 4'b0000);
        next_cycle();
        wbs_rty_i = 1'b0;
        set_m(3, 1'b0, 3'b000);
        set_m(1, 1'b1, 3'b010);
        next_cycle();
        wbs_ack_i = 1'b1;
        settle();
        check("mid_burst_grant", grant_o,   4'b0010);
        check("mid_burst_ack",   wbm_ack_o, 4'b0010);
        next_cycle();
        wb_rst_ni = 1'b0;
        settle();
        check("rst_edge_cyc", wbs_cyc_o, 1'b1);
        next_cycle();
        wb_rst_ni = 1'b1;
        wbs_ack_i = 1'b0;
        set_m(0, 1'b1, 3'b000);
        settle();
        check("post_rst_grant", grant_o,   4'b0000);
        check("post_rst_cyc",   wbs_cyc_o, 1'b0);
        check("post_rst_stb",   wbs_stb_o, 1'b0);
        check("post_rst_adr",   wbs_adr_o, 32'h0);
        check("post_rst_cti",   wbs_cti_o, 3'b000);
        check("post_rst_sel",   wbs_sel_o, 4'b0000);
        next_cycle();
        settle();
        check("post_rst_first", grant_o, 4'b0001);

        // ---- Watchdog: slave never answers m0; fires in stalled cycles 8, 16.
        do_reset();
        set_m(0, 1'b1, 3'b000);
        next_cycle();
        for (int c = 1; c <= 17; c++) begin
            settle();
            check($sformatf("wd_timeout_c%0d", c), timeout_o, (c == 8 || c == 16));
            check($sformatf("wd_err_c%0d", c),     wbm_err_o, (c == 8 || c == 16) ? 4'b0001 : 4'b0000);
            next_cycle();
        end
        settle();
        check("wd_grant_kept", grant_o, 4'b0001);

        // ---- Watchdog: ack in the 8th stalled cycle wins and restarts the count.
        do_reset();
        set_m(0, 1'b1, 3'b000);
        next_cycle();
        for (int c = 1; c <= 16; c++) begin
            wbs_ack_i = (c == 8);
            settle();
            check($sformatf("wdack_timeout_c%0d", c), timeout_o, (c == 16));
            check($sformatf("wdack_ack_c%0d", c),     wbm_ack_o, (c == 8) ? 4'b0001 : 4'b0000);
            check($sformatf("wdack_err_c%0d", c),     wbm_err_o, (c == 16) ? 4'b0001 : 4'b0000);
            next_cycle();
        end
        clear_bus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
